roll_scheduler: RTL

Controller that sequences the 4-bit LFSR datapath of the dice/random-number display. On a start request it issues one-cycle step enables to the LFSR at a geometrically decelerating rate over a fixed number of phases, captures the settled LFSR value as the roll result, and keeps a small history of past results that the user can scroll back through. It sits between the debounced key inputs and the LFSR/7-segment path. The LFSR itself is clocked by `i_clk` and gated by `o_step`, with no derived clocks.

---
 rtl/roll_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/roll_scheduler.sv
// rtl/roll_scheduler.sv - dice roll sequencer: decelerating LFSR steps, result latch, optional history ring (ROLL_HIST_EN)
module roll_scheduler #(
  parameter int BASE_INTERVAL   = 3125000,
  parameter int NUM_PHASES      = 5,
  parameter int STEPS_PER_PHASE = 16,
  parameter int HIST_DEPTH      = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic                        i_recall,
  input  logic [3:0]                  i_lfsr_value,
  output logic                        o_step,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [2:0]                  o_phase,
  output logic [3:0]                  o_value,
  output logic [$clog2(HIST_DEPTH):0] o_hist_cnt
);

  localparam int          MAX_IV = BASE_INTERVAL << (NUM_PHASES - 1);
  localparam int          CW     = ($clog2(MAX_IV) < 1) ? 1 : $clog2(MAX_IV);
  localparam int          SW     = $clog2(STEPS_PER_PHASE) + 1;
  localparam logic [31:0] BASE_U = 32'(BASE_INTERVAL);

  typedef enum logic [1:0] {IDLE, RUN, SETTLE, RECALL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] iv_cnt_q, iv_cnt_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [2:0]    phase_q, phase_d, phase_out_d;
  logic          last_q, last_d;
  logic [3:0]    result_q, result_d, value_d;
  logic          step_d, busy_d, done_d;
  logic [31:0]   iv_last;
  logic          iv_hit;

  assign iv_last = (BASE_U << phase_q) - 32'd1;
  assign iv_hit  = (32'(iv_cnt_q) == iv_last);

`ifdef ROLL_HIST_EN
  localparam int HW = $clog2(HIST_DEPTH);
  logic [3:0]    hist_q [HIST_DEPTH];
  logic [HW-1:0] wptr_q;
  logic [HW:0]   cnt_q, off_q, off_d;
  assign o_hist_cnt = cnt_q;
`else
  logic unused_recall;
  assign unused_recall = i_recall;
  assign o_hist_cnt    = '0;
`endif

  always_comb begin
    state_d     = state_q;
    iv_cnt_d    = iv_cnt_q;
    step_cnt_d  = step_cnt_q;
    phase_d     = phase_q;
    last_d      = last_q;
    result_d    = result_q;
    value_d     = o_value;
    step_d      = 1'b0;
    done_d      = 1'b0;
    phase_out_d = 3'd0;
`ifdef ROLL_HIST_EN
    off_d       = off_q;
`endif
    // start beats recall everywhere; SETTLE always runs to completion
    if (i_start && state_q != SETTLE) begin
      state_d    = RUN;
      iv_cnt_d   = '0;
      step_cnt_d = '0;
      phase_d    = '0;
      last_d     = 1'b0;
      value_d    = result_q;
    end else begin
      case (state_q)
        IDLE: begin
`ifdef ROLL_HIST_EN
          if (i_recall && cnt_q != '0) begin
            state_d = RECALL;
            off_d   = (HW+1)'(1);
            value_d = hist_q[wptr_q - HW'(1)];
          end
`endif
        end
        RUN: begin
`ifdef ROLL_HIST_EN
          if (i_recall) begin
            if (cnt_q != '0) begin
              state_d = RECALL;
              off_d   = (HW+1)'(1);
              value_d = hist_q[wptr_q - HW'(1)];
            end else begin
              state_d = IDLE;
            end
          end else
`endif
          // one extra RUN cycle after the final step lets the LFSR output settle
          if (last_q) begin
            state_d = SETTLE;
          end else begin
            phase_out_d = phase_q;
            if (iv_hit) begin
              step_d   = 1'b1;
              iv_cnt_d = '0;
              if (step_cnt_q == SW'(STEPS_PER_PHASE - 1)) begin
                step_cnt_d = '0;
                if (phase_q == 3'(NUM_PHASES - 1)) last_d = 1'b1;
                else phase_d = phase_q + 3'd1;
              end else begin
                step_cnt_d = step_cnt_q + SW'(1);
              end
            end else begin
              iv_cnt_d = iv_cnt_q + CW'(1);
            end
          end
        end
        SETTLE: begin
          result_d = i_lfsr_value;
          value_d  = i_lfsr_value;
          done_d   = 1'b1;
          last_d   = 1'b0;
          state_d  = IDLE;
        end
`ifdef ROLL_HIST_EN
        RECALL: begin
          if (i_recall) begin
            off_d   = (off_q == cnt_q) ? (HW+1)'(1) : off_q + (HW+1)'(1);
            value_d = hist_q[wptr_q - off_d[HW-1:0]];
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN) || (state_d == SETTLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      iv_cnt_q   <= '0;
      step_cnt_q <= '0;
      phase_q    <= '0;
      last_q     <= 1'b0;
      result_q   <= '0;
      o_step     <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_phase    <= '0;
      o_value    <= '0;
    end else begin
      state_q    <= state_d;
      iv_cnt_q   <= iv_cnt_d;
      step_cnt_q <= step_cnt_d;
      phase_q    <= phase_d;
      last_q     <= last_d;
      result_q   <= result_d;
      o_step     <= step_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
      o_phase    <= phase_out_d;
      o_value    <= value_d;
    end
  end

`ifdef ROLL_HIST_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      off_q  <= '0;
    end else begin
      off_q <= off_d;
      if (state_q == SETTLE) begin
        hist_q[wptr_q] <= i_lfsr_value;
        wptr_q         <= wptr_q + HW'(1);
        if (cnt_q != (HW+1)'(HIST_DEPTH)) cnt_q <= cnt_q + (HW+1)'(1);
      end
    end
  end
`endif

endmodule
